// File: rtl/pixel_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_pkg
// Purpose  : Shared types, screen geometry and scheduler state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package pixel_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int COORD_W  = 9;
    localparam int COLOUR_W = 12;

    typedef logic [COORD_W-1:0]  coord_t;
    typedef logic [COLOUR_W-1:0] colour_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_scheduler_if
// Purpose  : Engine dispatch/result bus plus the single-pixel write port.
// Revision : 1.0 - initial release
// ============================================================================
interface pixel_scheduler_if #(
    parameter int NUM_ENG = 4
) ();
    import pixel_pkg::*;

    logic                        frame_start;
    logic [NUM_ENG-1:0]          eng_start;
    coord_t                      eng_x;
    coord_t                      eng_y;
    logic [NUM_ENG-1:0]          eng_done;
    logic [COLOUR_W*NUM_ENG-1:0] eng_colour;
    logic [NUM_ENG-1:0]          eng_ack;
    logic                        plot;
    coord_t                      x;
    coord_t                      y;
    colour_t                     colour;
    logic                        busy;
    logic                        frame_done;

    modport master (
        input  frame_start, eng_done, eng_colour,
        output eng_start, eng_x, eng_y, eng_ack, plot, x, y, colour, busy, frame_done
    );

    modport slave (
        output frame_start, eng_done, eng_colour,
        input  eng_start, eng_x, eng_y, eng_ack, plot, x, y, colour, busy, frame_done
    );

endinterface
`default_nettype wire

// File: rtl/pixel_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter; search begins at i_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic      [N-1:0]     o_grant,
    output logic      [IDX_W-1:0] o_grant_idx,
    output logic                  o_grant_valid,
    output logic      [IDX_W-1:0] o_ptr_next
);

    int w_idx;

    always_comb begin
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        o_ptr_next    = i_ptr;
        w_idx         = 0;
        for (int off = 0; off < N; off++) begin
            w_idx = int'(i_ptr) + off;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!o_grant_valid && i_req[w_idx]) begin
                o_grant_valid  = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = IDX_W'(w_idx);
                // Next search starts just past the winner
                o_ptr_next     = (w_idx == N - 1) ? '0 : IDX_W'(w_idx + 1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pixel_scheduler
// Purpose  : Raster dispatch to NUM_ENG iteration engines, writeback of results.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_scheduler
    import pixel_pkg::*;
#(
    parameter int NUM_ENG = 4,
    parameter int WIDTH   = SCREEN_W,
    parameter int HEIGHT  = SCREEN_H
) (
    input wire logic          clock,
    input wire logic          reset,
    pixel_scheduler_if.master bus
);

    localparam int     IDX_W    = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam coord_t c_X_LAST = coord_t'(WIDTH - 1);
    localparam coord_t c_Y_LAST = coord_t'(HEIGHT - 1);

    state_t             r_state;
    state_t             w_state_next;
    coord_t             r_rx;
    coord_t             r_ry;
    logic [NUM_ENG-1:0] r_eng_busy;
    logic [NUM_ENG-1:0] r_stale;
    coord_t             r_px [NUM_ENG];
    coord_t             r_py [NUM_ENG];
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_next;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [NUM_ENG-1:0] w_req;
    logic [NUM_ENG-1:0] w_gnt;
    logic [NUM_ENG-1:0] w_start;
    logic               w_gnt_valid;
    logic               w_gnt_stale;
    logic               w_dispatch;
    logic               w_last_pixel;
    logic               w_frame_done_next;
    logic               r_plot;
    logic               r_frame_done;
    coord_t             r_x;
    coord_t             r_y;
    colour_t            r_colour;

    // Done from an engine we never dispatched is not a request
    assign w_req = bus.eng_done & r_eng_busy;

    rr_arbiter #(.N(NUM_ENG)) u_arb (
        .i_req        (w_req),
        .i_ptr        (r_ptr),
        .o_grant      (w_gnt),
        .o_grant_idx  (w_gnt_idx),
        .o_grant_valid(w_gnt_valid),
        .o_ptr_next   (w_ptr_next)
    );

    // A grant coinciding with a restart belongs to the aborted frame
    assign w_gnt_stale  = r_stale[w_gnt_idx] | bus.frame_start;
    assign w_last_pixel = (r_rx == c_X_LAST) && (r_ry == c_Y_LAST);

    always_comb begin
        w_start = '0;
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (!r_eng_busy[i]) begin
                w_start    = '0;
                w_start[i] = 1'b1;
            end
        end
        if ((r_state != ST_SCAN) || bus.frame_start) begin
            w_start = '0;
        end
    end

    assign w_dispatch = |w_start;

    always_comb begin
        w_state_next      = r_state;
        w_frame_done_next = 1'b0;
        case (r_state)
            ST_IDLE:  ;
            ST_SCAN:  if (w_dispatch && w_last_pixel) w_state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (r_eng_busy == '0) begin
                    w_state_next      = ST_IDLE;
                    w_frame_done_next = 1'b1;
                end
            end
            default:  w_state_next = ST_IDLE;
        endcase
        if (bus.frame_start) begin
            w_state_next      = ST_SCAN;
            w_frame_done_next = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx <= '0;
            r_ry <= '0;
        end else if (bus.frame_start) begin
            r_rx <= '0;
            r_ry <= '0;
        end else if (w_dispatch) begin
            if (r_rx == c_X_LAST) begin
                r_rx <= '0;
                r_ry <= w_last_pixel ? '0 : r_ry + 1'b1;
            end else begin
                r_rx <= r_rx + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_eng_busy <= '0;
            r_stale    <= '0;
            for (int i = 0; i < NUM_ENG; i++) begin
                r_px[i] <= '0;
                r_py[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENG; i++) begin
                if (w_gnt[i]) begin
                    r_eng_busy[i] <= 1'b0;
                    r_stale[i]    <= 1'b0;
                end else if (w_start[i]) begin
                    r_eng_busy[i] <= 1'b1;
                    r_px[i]       <= r_rx;
                    r_py[i]       <= r_ry;
                end else if (bus.frame_start && r_eng_busy[i]) begin
                    r_stale[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_plot   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_ptr    <= '0;
        end else begin
            r_plot <= w_gnt_valid && !w_gnt_stale;
            if (w_gnt_valid && !w_gnt_stale) begin
                r_x      <= r_px[w_gnt_idx];
                r_y      <= r_py[w_gnt_idx];
                r_colour <= bus.eng_colour[int'(w_gnt_idx)*COLOUR_W +: COLOUR_W];
            end
            if (w_gnt_valid) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    assign bus.eng_start  = w_start;
    assign bus.eng_x      = w_dispatch ? r_rx : '0;
    assign bus.eng_y      = w_dispatch ? r_ry : '0;
    assign bus.eng_ack    = w_gnt;
    assign bus.plot       = r_plot;
    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.colour     = r_colour;
    assign bus.busy       = (r_state == ST_SCAN) || (r_state == ST_DRAIN);
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire
